// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the ADC sampler slice: conversion FSM state
// encoding and the converter result width.
// Ports: none (package).
// ---------------------------------------------------------------------------
package adc_pkg;

    localparam int ADC_BITS = 12;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE
    } adc_state_e;

endpackage

// File: rtl/adc_sampler_if.sv
// ---------------------------------------------------------------------------
// adc_sampler_if
// Signals between the sampler and the ADC serial driver.
// Ports (members):
//   adc_cs           driver chip select, low while a conversion is running
//   adc_value        driver result, valid on the adc_cs rising edge
//   adc_read         one-cycle conversion request to the driver
//   adc_recalibrate  one-cycle recalibration request to the driver
// Modports: master = sampler side, slave = driver side.
// ---------------------------------------------------------------------------
interface adc_sampler_if;
    import adc_pkg::*;

    logic                adc_cs;
    logic [ADC_BITS-1:0] adc_value;
    logic                adc_read;
    logic                adc_recalibrate;

    modport master (
        input  adc_cs,
        input  adc_value,
        output adc_read,
        output adc_recalibrate
    );

    modport slave (
        output adc_cs,
        output adc_value,
        input  adc_read,
        input  adc_recalibrate
    );

endinterface

// File: rtl/adc_averager.sv
// ---------------------------------------------------------------------------
// adc_averager
// Block averager: sums 2^AVG_LOG2 captured samples and publishes the
// truncated mean, then restarts from zero.
// Ports:
//   clk, reset   system clock, async active-high reset
//   clear        drop the partial block (accumulator and count to 0)
//   strobe       capture strobe, din is a new sample this cycle
//   din          captured sample
//   avg_value    last block average (held between blocks)
//   avg_valid    one-cycle pulse, the cycle after the block's last strobe
// ---------------------------------------------------------------------------
module adc_averager
    import adc_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                strobe,
    input  logic [ADC_BITS-1:0] din,
    output logic [ADC_BITS-1:0] avg_value,
    output logic                avg_valid
);

    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    // keep the count at least one bit wide so AVG_LOG2 = 0 still elaborates
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] sum_nxt;

    // sized so a full block can never overflow
    assign sum_nxt = acc + ACC_W'(din);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            avg_value <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (strobe) begin
                if (cnt == CNT_LAST) begin
                    avg_value <= sum_nxt[AVG_LOG2 +: ADC_BITS];
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum_nxt;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// ---------------------------------------------------------------------------
// adc_sampler
// Periodic conversion scheduler and sample conditioner above the ADC serial
// driver. Requests a conversion every SAMPLE_PERIOD cycles, detects
// completion from adc_cs, captures the result, block-averages it and flags
// over-level samples. A stuck conversion times out and asks the driver to
// recalibrate.
// Optional build macro: ADC_SAMPLER_TRIP_EN builds the trip comparator and
// sticky flag; without it trip is tied low and trip_clear is ignored.
// Ports:
//   clk, reset       system clock, async active-high reset
//   enable           run scheduling while high
//   trip_clear       clear the sticky trip flag
//   adc              driver bus (adc_sampler_if.master)
//   sample           last captured raw sample
//   sample_valid     one-cycle pulse, sample updated
//   avg_value        last block average
//   avg_valid        one-cycle pulse, avg_value updated
//   trip             sticky over-level flag
//   timeout_err      one-cycle pulse on conversion timeout
//   overrun          one-cycle pulse when a period tick finds the FSM busy
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | waiting for a period tick
// REQ       | adc_read asserted for this cycle
// WAIT_LOW  | waiting for the driver to drop adc_cs
// WAIT_HIGH | conversion running, waiting for adc_cs to rise
// CAPTURE   | sample registered, sample_valid asserted
// ---------------------------------------------------------------------------
module adc_sampler
    import adc_pkg::*;
#(
    parameter int                  SAMPLE_PERIOD = 1000,
    parameter int                  AVG_LOG2      = 3,
    parameter logic [ADC_BITS-1:0] TRIP_LEVEL    = 12'd3500,
    parameter int                  TIMEOUT       = 200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                trip_clear,
    adc_sampler_if.master       adc,
    output logic [ADC_BITS-1:0] sample,
    output logic                sample_valid,
    output logic [ADC_BITS-1:0] avg_value,
    output logic                avg_valid,
    output logic                trip,
    output logic                timeout_err,
    output logic                overrun
);

    localparam int PER_W = $clog2(SAMPLE_PERIOD);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    adc_state_e       state;
    adc_state_e       state_nxt;
    logic [PER_W-1:0] per_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             tick;
    logic             cs_q;
    logic             cs_fall;
    logic             cs_rise;
    logic             to_hit;
    logic             capture_en;
    logic             read_req;
    logic             recal_req;
    logic             avg_clear;

    // ---- period timer ----
    assign tick = enable && (per_cnt == PER_W'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
        end else if (!enable || tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // ---- chip-select edge detect (idle level of cs is high) ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q <= 1'b1;
        end else begin
            cs_q <= adc.adc_cs;
        end
    end

    assign cs_fall = cs_q && !adc.adc_cs;
    assign cs_rise = !cs_q && adc.adc_cs;

    // ---- conversion timeout ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == REQ) begin
            to_cnt <= '0;
        end else if (state == WAIT_LOW || state == WAIT_HIGH) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (to_cnt == TO_W'(TIMEOUT));

    // ---- FSM ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        read_req     = 1'b0;
        recal_req    = 1'b0;
        timeout_err  = 1'b0;
        sample_valid = 1'b0;
        capture_en   = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                read_req  = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (to_hit) begin
                    timeout_err = 1'b1;
                    recal_req   = 1'b1;
                    state_nxt   = IDLE;
                end else if (cs_fall) begin
                    state_nxt = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // a rise coinciding with the timeout is treated as too late
                if (to_hit) begin
                    timeout_err = 1'b1;
                    recal_req   = 1'b1;
                    state_nxt   = IDLE;
                end else if (cs_rise) begin
                    capture_en = 1'b1;
                    state_nxt  = CAPTURE;
                end
            end
            CAPTURE: begin
                sample_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign overrun             = tick && (state != IDLE);
    assign adc.adc_read        = read_req;
    assign adc.adc_recalibrate = recal_req;

    // ---- sample capture ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample <= '0;
        end else if (capture_en) begin
            sample <= adc.adc_value;
        end
    end

    // ---- trip ----
`ifdef ADC_SAMPLER_TRIP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trip <= 1'b0;
        end else if (capture_en && (adc.adc_value >= TRIP_LEVEL)) begin
            trip <= 1'b1;
        end else if (trip_clear) begin
            trip <= 1'b0;
        end
    end
`else
    logic unused_trip;
    assign unused_trip = trip_clear ^ (^TRIP_LEVEL);
    assign trip        = 1'b0;
`endif

    // ---- block average; a partial block is dropped while parked disabled ----
    assign avg_clear = !enable && (state == IDLE);

    adc_averager #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_averager (
        .clk       (clk),
        .reset     (reset),
        .clear     (avg_clear),
        .strobe    (capture_en),
        .din       (adc.adc_value),
        .avg_value (avg_value),
        .avg_valid (avg_valid)
    );

endmodule

// File: tb/tb_adc_sampler.sv
// ---------------------------------------------------------------------------
// tb_adc_sampler
// Drives adc_sampler with a behavioural ADC driver (cs drops some cycles
// after adc_read, stays low, then rises with the result) and checks it
// against an event-level model: per-conversion expected sample, a list of
// block samples averaged with plain arithmetic, a sticky trip flag, and
// expected request/timeout/overrun timing derived from the fixed tick grid.
// ---------------------------------------------------------------------------
module tb_adc_sampler;
    import adc_pkg::*;

    localparam int                  PER  = 100;
    localparam int                  L2   = 2;
    localparam int                  TO   = 200;
    localparam logic [ADC_BITS-1:0] TRIP = 12'd3500;
`ifdef ADC_SAMPLER_TRIP_EN
    localparam bit TRIP_BUILT = 1'b1;
`else
    localparam bit TRIP_BUILT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                trip_clear;
    logic [ADC_BITS-1:0] sample;
    logic                sample_valid;
    logic [ADC_BITS-1:0] avg_value;
    logic                avg_valid;
    logic                trip;
    logic                timeout_err;
    logic                overrun;

    adc_sampler_if bus ();

    adc_sampler #(
        .SAMPLE_PERIOD (PER),
        .AVG_LOG2      (L2),
        .TRIP_LEVEL    (TRIP),
        .TIMEOUT       (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .trip_clear   (trip_clear),
        .adc          (bus),
        .sample       (sample),
        .sample_valid (sample_valid),
        .avg_value    (avg_value),
        .avg_valid    (avg_valid),
        .trip         (trip),
        .timeout_err  (timeout_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_read = 0, n_sv = 0, n_to = 0, n_rc = 0, n_ov = 0;
    int last_read = -1, last_to = -1, last_rc = -1, last_ov = -1;
    int blk[$];
    bit exp_trip = 1'b0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    // advance one cycle and log the pulses seen in the new cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.adc_read)        begin n_read++; last_read = cyc; end
        if (bus.adc_recalibrate) begin n_rc++;   last_rc   = cyc; end
        if (timeout_err)         begin n_to++;   last_to   = cyc; end
        if (overrun)             begin n_ov++;   last_ov   = cyc; end
        if (sample_valid)        n_sv++;
    endtask

    task automatic wait_read(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.adc_read && n < 300);
        if (!bus.adc_read) chk("read_wait_expired", 0, 1);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_adc_read"}, bus.adc_read, 0);
        chk({pfx, "_recal"}, bus.adc_recalibrate, 0);
        chk({pfx, "_sample"}, sample, 0);
        chk({pfx, "_sample_valid"}, sample_valid, 0);
        chk({pfx, "_avg_value"}, avg_value, 0);
        chk({pfx, "_avg_valid"}, avg_valid, 0);
        chk({pfx, "_trip"}, trip, 0);
        chk({pfx, "_timeout_err"}, timeout_err, 0);
        chk({pfx, "_overrun"}, overrun, 0);
    endtask

    // called in the cycle adc_read was seen; completes one conversion
    task automatic do_conv(input logic [ADC_BITS-1:0] v, input int dly,
                           input int low, input bit clr);
        int sv0;
        int s;
        sv0 = n_sv;
        repeat (dly) step();
        bus.adc_cs = 1'b0;
        repeat (low) step();
        bus.adc_value = v;
        bus.adc_cs    = 1'b1;
        trip_clear    = clr;
        step();
        trip_clear = 1'b0;
        chk("sample_valid", sample_valid, 1);
        chk("sample", sample, v);
        chk("sv_count", n_sv - sv0, 1);
        if (v >= TRIP) exp_trip = 1'b1;
        else if (clr)  exp_trip = 1'b0;
        chk("trip", trip, TRIP_BUILT ? exp_trip : 1'b0);
        blk.push_back(int'(v));
        if (blk.size() == (1 << L2)) begin
            s = 0;
            foreach (blk[i]) s += blk[i];
            chk("avg_valid_end", avg_valid, 1);
            chk("avg_value", avg_value, s >> L2);
            blk.delete();
        end else begin
            chk("avg_valid_mid", avg_valid, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, prev, r, k, ov0, sv0, rc0, rd0;
        int avgs[4];
        logic [ADC_BITS-1:0] v;

        reset = 1'b1; enable = 1'b1; trip_clear = 1'b0;
        bus.adc_cs = 1'b1; bus.adc_value = '0;
        repeat (3) step();
        chk_all_zero("rst");
        reset = 1'b0;

        wait_read(n);
        chk("first_read_latency", n, PER);

        // constant driver value, cs dropping 40 cycles after the request
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                prev = last_read;
                wait_read(n);
                chk("read_period", last_read - prev, PER);
            end
            do_conv(12'h123, 40, 10, 1'b0);
        end

        avgs = '{100, 101, 102, 104};
        for (int i = 0; i < 4; i++) begin
            prev = last_read;
            wait_read(n);
            chk("read_period", last_read - prev, PER);
            do_conv(ADC_BITS'(avgs[i]), $urandom_range(1, 20), $urandom_range(1, 30), 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            prev = last_read;
            ov0  = n_ov;
            wait_read(n);
            chk("read_period", last_read - prev, PER);
            do_conv(ADC_BITS'($urandom_range(0, 4095)), $urandom_range(0, 20),
                    $urandom_range(1, 40), 1'b0);
            chk("no_overrun", n_ov - ov0, 0);
        end

        // trip: exact threshold, low value, clear colliding with a set
        wait_read(n);
        do_conv(12'd3500, 5, 5, 1'b0);
        wait_read(n);
        do_conv(12'd10, 5, 5, 1'b0);
        wait_read(n);
        do_conv(12'd3600, 5, 5, 1'b1);
        trip_clear = 1'b1;
        step();
        trip_clear = 1'b0;
        step();
        exp_trip = 1'b0;
        chk("trip_after_clear", trip, 0);

        // conversion longer than the period
        wait_read(n);
        r   = last_read;
        ov0 = n_ov;
        do_conv(ADC_BITS'($urandom_range(0, 3000)), 5, 150, 1'b0);
        chk("overrun_count", n_ov - ov0, 1);
        chk("overrun_at_tick", last_ov - r, PER - 1);

        // stuck driver: cs never drops
        wait_read(n);
        chk("read_after_overrun", last_read - r, 2 * PER);
        r   = last_read;
        ov0 = n_ov;
        sv0 = n_sv;
        rc0 = n_rc;
        k   = 0;
        do begin
            step();
            k++;
        end while (!timeout_err && k < 300);
        chk("timeout_latency", last_to - r, TO + 1);
        chk("recal_with_timeout", last_rc, last_to);
        wait_read(n);
        chk("read_after_timeout", last_read - r, 3 * PER);
        chk("recal_count", n_rc - rc0, 1);
        chk("timeout_no_capture", n_sv - sv0, 0);
        chk("timeout_overruns", n_ov - ov0, 2);

        // enable dropped mid-conversion: finishes, then parks and drops partial
        enable = 1'b0;
        v = ADC_BITS'($urandom_range(0, 3000));
        do_conv(v, 10, 10, 1'b0);
        blk.delete();
        rd0 = n_read;
        repeat (150) step();
        chk("no_read_disabled", n_read - rd0, 0);
        chk("sample_retained", sample, v);
        enable = 1'b1;
        wait_read(n);
        chk("read_after_enable", n, PER);
        do_conv(ADC_BITS'($urandom_range(0, 4095)), 3, 8, 1'b0);

        // reset while waiting for cs to rise
        wait_read(n);
        repeat (3) step();
        bus.adc_cs = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk_all_zero("midrst");
        reset      = 1'b0;
        bus.adc_cs = 1'b1;
        blk.delete();
        exp_trip = 1'b0;
        sv0 = n_sv;
        wait_read(n);
        chk("read_after_reset", n, PER);
        chk("reset_no_capture", n_sv - sv0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                prev = last_read;
                wait_read(n);
                chk("read_period", last_read - prev, PER);
            end
            do_conv(ADC_BITS'($urandom_range(0, 4095)), $urandom_range(0, 20),
                    $urandom_range(1, 40), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
